// File: rtl/train_scheduler.sv
// Trial sequencer for the two-neuron STDP network: stimulus/rest phases per trial, spike counting, record handshake.
// Optional early stop on N2 spike count is enabled by defining TRAIN_SCHED_EARLY_STOP_EN.
module train_scheduler #(
  parameter logic [7:0] STIM_CYCLES = 8'd16,
  parameter logic [7:0] REST_CYCLES = 8'd8,
  parameter logic [7:0] NUM_TRIALS  = 8'd4,
  parameter logic [7:0] TARGET_N2   = 8'd4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       n1_spike,
  input  logic       n2_spike,
  input  logic [7:0] weight_in,
  output logic       stim_out,
  output logic       busy,
  output logic       done,
  output logic       converged,
  output logic       rec_valid,
  input  logic       rec_ready,
  output logic [7:0] rec_trial,
  output logic [7:0] rec_n1_count,
  output logic [7:0] rec_n2_count,
  output logic [7:0] rec_weight,
  output logic [1:0] state_dbg
);

  // Record handshake: a record transfers on any rising edge where rec_valid && rec_ready;
  // rec_valid never drops and the fields never change before that edge (abort excepted).
  typedef enum logic [1:0] {S_IDLE, S_STIM, S_REST, S_REPORT} state_t;

  state_t     state;
  logic [7:0] phase_cnt;
  logic [7:0] trial;
  logic [7:0] n1_cnt;
  logic [7:0] n2_cnt;
  logic [7:0] n1_nxt;
  logic [7:0] n2_nxt;
  logic       handshake;
  logic       early_stop;
  logic       session_end;

  assign n1_nxt    = (n1_spike && n1_cnt != 8'hFF) ? n1_cnt + 8'd1 : n1_cnt;
  assign n2_nxt    = (n2_spike && n2_cnt != 8'hFF) ? n2_cnt + 8'd1 : n2_cnt;
  assign handshake = rec_valid && rec_ready;

`ifdef TRAIN_SCHED_EARLY_STOP_EN
  assign early_stop = (rec_n2_count >= TARGET_N2);
`else
  logic unused_target;
  assign early_stop    = 1'b0;
  assign unused_target = ^TARGET_N2;
`endif

  assign session_end = (trial == NUM_TRIALS - 8'd1) || early_stop;
  assign busy        = (state != S_IDLE);
  assign state_dbg   = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      phase_cnt    <= 8'd0;
      trial        <= 8'd0;
      n1_cnt       <= 8'd0;
      n2_cnt       <= 8'd0;
      stim_out     <= 1'b0;
      done         <= 1'b0;
      converged    <= 1'b0;
      rec_valid    <= 1'b0;
      rec_trial    <= 8'd0;
      rec_n1_count <= 8'd0;
      rec_n2_count <= 8'd0;
      rec_weight   <= 8'd0;
    end else begin
      done <= 1'b0;
      // Abort outranks every phase transition and any handshake on the same edge.
      if (abort && state != S_IDLE) begin
        state     <= S_IDLE;
        stim_out  <= 1'b0;
        rec_valid <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            phase_cnt <= 8'd0;
            trial     <= 8'd0;
            n1_cnt    <= 8'd0;
            n2_cnt    <= 8'd0;
            if (start) begin
              state     <= S_STIM;
              stim_out  <= 1'b1;
              converged <= 1'b0;
            end
          end
          S_STIM: begin
            n1_cnt <= n1_nxt;
            n2_cnt <= n2_nxt;
            if (phase_cnt == STIM_CYCLES - 8'd1) begin
              state     <= S_REST;
              phase_cnt <= 8'd0;
              stim_out  <= 1'b0;
            end else begin
              phase_cnt <= phase_cnt + 8'd1;
            end
          end
          S_REST: begin
            n1_cnt    <= n1_nxt;
            n2_cnt    <= n2_nxt;
            phase_cnt <= phase_cnt + 8'd1;
            if (phase_cnt == REST_CYCLES - 8'd1) begin
              state        <= S_REPORT;
              rec_valid    <= 1'b1;
              rec_trial    <= trial;
              rec_n1_count <= n1_nxt;
              rec_n2_count <= n2_nxt;
              rec_weight   <= weight_in;
            end
          end
          S_REPORT: begin
            if (handshake) begin
              rec_valid <= 1'b0;
              if (session_end) begin
                state     <= S_IDLE;
                done      <= 1'b1;
                converged <= early_stop;
              end else begin
                state     <= S_STIM;
                stim_out  <= 1'b1;
                trial     <= trial + 8'd1;
                n1_cnt    <= 8'd0;
                n2_cnt    <= 8'd0;
                phase_cnt <= 8'd0;
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_train_scheduler.sv
// Randomized scoreboard bench for train_scheduler: spec-timed driver, reference model of records,
// and a negedge monitor comparing outputs and popping expected records on handshake/abort.
module tb_train_scheduler;
  localparam int S   = 16;
  localparam int R   = 8;
  localparam int NT  = 4;
  localparam int TGT = 4;
  localparam int SAT_S = 255;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, abort, n1_spike, n2_spike, rec_ready;
  logic [7:0] weight_in;
  logic       stim_out, busy, done, converged, rec_valid;
  logic [7:0] rec_trial, rec_n1_count, rec_n2_count, rec_weight;
  logic [1:0] state_dbg;

  logic       sat_start;
  logic       sat_stim, sat_busy, sat_done, sat_conv, sat_valid;
  logic [7:0] sat_trial, sat_n1, sat_n2, sat_w;
  logic [1:0] sat_state;

  train_scheduler dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .n1_spike(n1_spike), .n2_spike(n2_spike), .weight_in(weight_in),
    .stim_out(stim_out), .busy(busy), .done(done), .converged(converged),
    .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_trial(rec_trial),
    .rec_n1_count(rec_n1_count), .rec_n2_count(rec_n2_count),
    .rec_weight(rec_weight), .state_dbg(state_dbg)
  );

  train_scheduler #(.STIM_CYCLES(8'd255), .REST_CYCLES(8'd8), .NUM_TRIALS(8'd1),
                    .TARGET_N2(8'd255)) dut_sat (
    .clk(clk), .rst(rst), .start(sat_start), .abort(1'b0),
    .n1_spike(1'b1), .n2_spike(1'b1), .weight_in(8'h5A),
    .stim_out(sat_stim), .busy(sat_busy), .done(sat_done), .converged(sat_conv),
    .rec_valid(sat_valid), .rec_ready(1'b1), .rec_trial(sat_trial),
    .rec_n1_count(sat_n1), .rec_n2_count(sat_n2),
    .rec_weight(sat_w), .state_dbg(sat_state)
  );

  // scoreboard state
  logic [31:0] exp_q[$];
  logic [31:0] sat_q[$];
  logic exp_stim, exp_busy, exp_valid, exp_done, exp_conv;
  logic mon_en;
  int   n_vec = 0;
  int   n_err = 0;
  int   sat_done_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] sat8(input int v);
    return (v > 255) ? 8'hFF : 8'(v);
  endfunction

  // monitor: expectations describe the window after the preceding rising edge
  always @(negedge clk) begin
    #1;
    if (mon_en) begin
      chk("stim_out", 32'(stim_out), 32'(exp_stim));
      chk("busy", 32'(busy), 32'(exp_busy));
      chk("rec_valid", 32'(rec_valid), 32'(exp_valid));
      chk("done", 32'(done), 32'(exp_done));
      chk("converged", 32'(converged), 32'(exp_conv));
      if (rec_valid) begin
        chk("record expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          chk("record fields", {rec_trial, rec_n1_count, rec_n2_count, rec_weight}, exp_q[0]);
          if (rec_ready || abort) void'(exp_q.pop_front());
        end
      end
    end
  end

  always @(negedge clk) begin
    #1;
    if (sat_done) sat_done_cnt++;
    if (sat_valid) begin
      chk("sat record expected", 32'(sat_q.size() != 0), 32'd1);
      if (sat_q.size() != 0) begin
        chk("sat record fields", {sat_trial, sat_n1, sat_n2, sat_w}, sat_q[0]);
        void'(sat_q.pop_front());
      end
    end
  end

  // driver tasks
  task automatic gen(input int mode, input int t, input int c, output logic a, output logic b);
    case (mode)
      0: begin
        a = (c < S) && ((c % 3 == 2) || c == 15);
        b = 1'b0;
      end
      2: begin
        a = ($urandom_range(0, 99) < 30);
        b = (t == 1) && (c == 3 || c == 7 || c == 12 || c == 17 || c == 21);
      end
      default: begin
        a = ($urandom_range(0, 99) < 30);
        b = ($urandom_range(0, 99) < 10);
      end
    endcase
  endtask

  task automatic noise();
    n1_spike  = 1'($urandom_range(0, 1));
    n2_spike  = 1'($urandom_range(0, 1));
    weight_in = 8'($urandom);
  endtask

  task automatic run_session(input int mode, input int abort_trial, input int bp_trial);
    int n1c, n2c, waits;
    logic [7:0] w;
    logic a, b;
    bit es, last, stop;
    start = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    exp_conv = 1'b0;
    stop     = 1'b0;
    for (int t = 0; t < NT && !stop; t++) begin
      n1c = 0;
      n2c = 0;
      w   = 8'd0;
      for (int c = 0; c < S + R; c++) begin
        exp_stim  = (c < S);
        exp_busy  = 1'b1;
        exp_valid = 1'b0;
        gen(mode, t, c, a, b);
        n1_spike  = a;
        n2_spike  = b;
        weight_in = 8'($urandom);
        rec_ready = 1'($urandom_range(0, 1));
        n1c += int'(a);
        n2c += int'(b);
        w = weight_in;
        @(negedge clk);
      end
      exp_q.push_back({8'(t), sat8(n1c), sat8(n2c), w});
      exp_stim  = 1'b0;
      exp_valid = 1'b1;
      waits = (t == bp_trial) ? 10 : $urandom_range(0, 3);
      for (int k = 0; k < waits; k++) begin
        rec_ready = 1'b0;
        noise();
        @(negedge clk);
      end
      rec_ready = 1'b1;
      noise();
      if (t == abort_trial) begin
        abort = 1'b1;
        @(negedge clk);
        abort     = 1'b0;
        exp_busy  = 1'b0;
        exp_valid = 1'b0;
        stop      = 1'b1;
      end else begin
        es = 1'b0;
`ifdef TRAIN_SCHED_EARLY_STOP_EN
        es = (n2c >= TGT);
`endif
        last = (t == NT - 1) || es;
        @(negedge clk);
        if (last) begin
          exp_valid = 1'b0;
          exp_busy  = 1'b0;
          exp_done  = 1'b1;
          exp_conv  = es;
          stop      = 1'b1;
          rec_ready = 1'b0;
          @(negedge clk);
          exp_done = 1'b0;
        end
      end
    end
    rec_ready = 1'b0;
    n1_spike  = 1'b0;
    n2_spike  = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // main sequence
  initial begin
    int n;
    rst = 1'b1; start = 1'b0; abort = 1'b0; n1_spike = 1'b0; n2_spike = 1'b0;
    rec_ready = 1'b0; weight_in = 8'd0; sat_start = 1'b0;
    exp_stim = 1'b0; exp_busy = 1'b0; exp_valid = 1'b0; exp_done = 1'b0; exp_conv = 1'b0;
    mon_en = 1'b0;
    repeat (3) @(negedge clk);
    mon_en = 1'b1;
    chk("reset record fields", {rec_trial, rec_n1_count, rec_n2_count, rec_weight}, 32'd0);
    rst = 1'b0;

    // saturation: spikes held high through 255 stim + 8 rest cycles
    n = 0;
    for (int c = 0; c < SAT_S + R; c++) if (n < 255) n++;
    sat_q.push_back({8'd0, 8'(n), 8'(n), 8'h5A});
    sat_start = 1'b1;
    @(negedge clk);
    sat_start = 1'b0;
    repeat (SAT_S + R + 6) @(negedge clk);
    chk("sat record drained", 32'(sat_q.size()), 32'd0);
    chk("sat done pulses", 32'(sat_done_cnt), 32'd1);

    run_session(0, -1, -1);
    run_session(1, -1, 0);
    run_session(2, -1, -1);

    // reset in the middle of STIM
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; exp_stim = 1'b1; exp_busy = 1'b1; exp_conv = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; exp_stim = 1'b0; exp_busy = 1'b0; exp_valid = 1'b0;
    chk("mid-stim reset record fields", {rec_trial, rec_n1_count, rec_n2_count, rec_weight}, 32'd0);
    repeat (2) @(negedge clk);

    run_session(0, 1, -1);
    run_session(1, -1, 2);
    run_session(2, -1, 1);

    chk("leftover records", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/train_scheduler.md
# train_scheduler

Trial sequencer for the two-neuron STDP network. Runs a training session of NUM_TRIALS trials. Each trial has a stimulus phase that drives the network's global spike input, then a rest phase that lets membrane potentials leak back down. During each trial the block counts N1 and N2 spikes and, at trial end, reports the counts plus a synaptic-weight snapshot over a valid/ready record interface. It sits between the test/host logic and the network's spike_in_global / spike_out_n1 / spike_out_n2 / syn_weight signals.

## Interface
- STIM_CYCLES, 8'd16: stimulus phase length in cycles; legal 1..255.
- REST_CYCLES, 8'd8: rest phase length in cycles; legal 1..255.
- NUM_TRIALS, 8'd4: trials per session; legal 1..255.
- TARGET_N2, 8'd4: early-stop N2 spike threshold; used only with TRAIN_SCHED_EARLY_STOP_EN.

Ports:
- clk  in  1  sole clock; all state changes on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  session start request; sampled only in IDLE.
- abort  in  1  cancel the session; return to IDLE on the next edge.
- n1_spike  in  1  from network spike_out_n1.
- n2_spike  in  1  from network spike_out_n2.
- weight_in  in  8  from network syn_weight.
- stim_out  out  1  to network spike_in_global; registered.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a session completes normally.
- converged  out  1  session ended by early stop; held until the next start or rst.
- rec_valid  out  1  trial record valid.
- rec_ready  in  1  consumer accepts the record.
- rec_trial  out  8  index of the trial, 0-based.
- rec_n1_count  out  8  N1 spikes in the trial, saturating.
- rec_n2_count  out  8  N2 spikes in the trial, saturating.
- rec_weight  out  8  weight_in sampled on the trial's final rest cycle.

## Operation
- FSM states: IDLE, STIM, REST, REPORT.
- IDLE
  - start=1 -> STIM.
  - Clear trial index, phase counter, spike counters and converged.
  - start is ignored outside IDLE.
- STIM
  - stim_out=1.
  - phase_cnt increments each cycle.
  - At phase_cnt==STIM_CYCLES-1: go to REST and set phase_cnt=0.
- REST
  - stim_out=0.
  - At phase_cnt==REST_CYCLES-1: go to REPORT.
  - On that same edge, latch the record: counts including that cycle's spikes, weight_in, and the trial index.
- REPORT
  - rec_valid=1; record fields stay stable until the handshake.
  - Handshake = rec_valid && rec_ready on one edge.
  - On handshake, if trial==NUM_TRIALS-1: go to IDLE and pulse done.
  - Otherwise: increment trial, clear the spike counters, set phase_cnt=0, go to STIM.
- Spike counting
  - n1_spike and n2_spike are counted on every edge while in STIM or REST.
  - REST counting captures late N2 spikes caused by the synaptic delay.
  - Spikes are not counted in REPORT or IDLE.
  - Counters saturate at 8'hFF and never wrap.
- Abort
  - abort=1 in STIM, REST or REPORT -> IDLE on the next edge.
  - stim_out=0, rec_valid=0, no done pulse, and any pending record is discarded.
  - abort takes priority over the handshake and over phase transitions on the same edge.
  - abort in IDLE has no effect, even if start is also high.
- rst has priority over everything else. Reset values:
  - state=IDLE.
  - stim_out, busy, done, converged, rec_valid = 0.
  - All counters and record fields = 0.
- The block never drives the network reset: synaptic weights persist across trials and sessions.

## Timing
- start sampled at edge E -> state=STIM after E. stim_out and busy are first high in the cycle after E.
- stim_out is high for exactly STIM_CYCLES consecutive cycles per trial, then low for REST_CYCLES cycles.
- rec_valid rises in the cycle after the last rest cycle.
- Minimum gap between the end of one trial's STIM and the start of the next trial's STIM: REST_CYCLES+1 cycles, with rec_ready held high.
- Trial period with rec_ready high: STIM_CYCLES+REST_CYCLES+1 cycles.
- done is high for one cycle, concurrent with busy falling.
- Back-pressure: REPORT may last indefinitely. stim_out stays 0 during REPORT and counters are frozen.

## Configuration
- TRAIN_SCHED_EARLY_STOP_EN defined
  - Early stop applies on a REPORT handshake whose rec_n2_count>=TARGET_N2.
  - In that case the session ends: go to IDLE, pulse done, set converged=1.
  - This happens even if trials remain.
- TRAIN_SCHED_EARLY_STOP_EN undefined
  - All NUM_TRIALS trials always run.
  - converged is tied to 0 and TARGET_N2 is unused.

## Test plan
- Reset mid-STIM
  - Stimulus: assert rst with default parameters.
  - Required: next cycle all outputs 0 and state IDLE; a later start runs a full session.
- Nominal session
  - Stimulus: defaults, rec_ready tied high, n1_spike every 3rd STIM cycle, n2_spike never.
  - Required: 4 records with rec_trial 0..3, rec_n1_count=6 (spikes on STIM cycles 2, 5, 8, 11, 14 and 15 — define the pulse pattern so exactly 6 land in STIM), rec_n2_count=0; done at cycle 4×25 after start.
  - Required: stim_out high for exactly 16 cycles per trial.
- Back-pressure
  - Stimulus: hold rec_ready=0 for 10 cycles in REPORT.
  - Required: record fields stable, stim_out=0, no counting; the next STIM starts the cycle after the handshake.
- Saturation
  - Stimulus: STIM_CYCLES=255, REST_CYCLES=8, n1_spike and n2_spike held high.
  - Required: both counts = 255, not wrapped.
- Abort priority
  - Stimulus: abort and rec_ready both high on the REPORT edge of trial 1.
  - Required: IDLE next cycle, no done, no trial-2 STIM.
- Early stop
  - Stimulus: TRAIN_SCHED_EARLY_STOP_EN defined, TARGET_N2=4, 5 n2 spikes in trial 1.
  - Required: done and converged=1 after the trial-1 handshake, no trial 2.
  - Same stimulus with the macro undefined: all 4 trials run and converged=0.
